stimulus_signature_unit: RTL and testbench
==========================================

// Module: stimulus_signature_unit
// PURPOSE
//   Self-test harness for the student circuit: drives pseudo-random 8-bit vectors
//   from a seeded LFSR into the circuit under test and compresses its 8-bit
//   responses into a 16-bit MISR signature.
//   Sits between the exam testbench/top level and the student circuit.
//   The resulting signature is compared against a published value per seed.
// PARAMETERS
//   NUM_VECTORS    256  number of response samples folded into the signature (>=1)
//   CAPTURE_DELAY  0    DUT pipeline latency in clk cycles (0..3); 0 = combinational DUT
// PORTS
//   clk         in   1   rising-edge clock, single clock domain
//   clear       in   1   synchronous, active-high reset
//   start       in   1   begin a run; honoured only in IDLE or DONE
//   seed        in   8   LFSR seed, sampled on the accepted start cycle
//   dut_output  in   8   response from circuit under test (its cct_output)
//   dut_input   out  8   stimulus to circuit under test (its cct_input)
//   dut_clear   out  1   clear to circuit under test; high for exactly the INIT cycle
//   busy        out  1   high in INIT and RUN
//   done        out  1   high in DONE; signature valid
//   signature   out  16  MISR contents; held stable in DONE
// BEHAVIOUR
//   Reset: state=IDLE; dut_input=0, dut_clear=0, busy=0, done=0, signature=0, count=0.
//   clear wins over every other input in any state, including mid-run; run aborted.
//   FSM: IDLE -start-> INIT -> RUN -(count==NUM_VECTORS+CAPTURE_DELAY-1)-> DONE -start-> INIT.
//   start in INIT/RUN ignored. No start in DONE: remain in DONE indefinitely.
//   Accepted start: lfsr<=(seed==0 ? 8'h01 : seed); misr<=0; count<=0; done<=0.
//   INIT (1 cycle): dut_clear=1, dut_input=lfsr (seed value); no capture, no LFSR step.
//   RUN: dut_input=lfsr; lfsr steps every RUN cycle; count increments every RUN cycle.
//   LFSR step (Galois, x^8+x^4+x^3+x^2+1, maximal length 255):
//     lfsr <= {lfsr[6:0],1'b0} ^ (lfsr[7] ? 8'h1D : 8'h00).
//   Capture: only in RUN cycles with count >= CAPTURE_DELAY (exactly NUM_VECTORS captures):
//     misr <= {misr[14:0],1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000) ^ {8'h00, dut_output}.
//   dut_output sampled at the clk edge ending the RUN cycle (same-cycle for delay 0).
//   signature = misr register (registered output, no combinational path from dut_output).
//   DONE: done=1, busy=0, dut_input holds last value, dut_clear=0, signature frozen.
//   Total run latency from accepted start to done=1: NUM_VECTORS+CAPTURE_DELAY+1 cycles.
//   count width: $clog2(NUM_VECTORS+CAPTURE_DELAY+1); no wrap within a legal run.
//   All outputs registered or decoded from state register only; dut_clear glitch-free.
// TESTING (pass-through DUT: dut_output=dut_input unless stated)
//   1. NUM_VECTORS=1, seed 8'hAA, start -> dut_clear high 1 cycle, done after 2 cycles,
//      signature=16'h00AA.
//   2. NUM_VECTORS=2, seed 8'hAA -> dut_input sequence AA,49; signature=16'h011D.
//   3. NUM_VECTORS=1, seed 8'h00 -> dut_input=8'h01, signature=16'h0001 (lockup avoided).
//   4. dut_output tied 8'h00, NUM_VECTORS=256, any seed -> signature=16'h0000, done at cycle 257.
//   5. CAPTURE_DELAY=1 with 1-cycle registered pass-through, NUM_VECTORS=2, seed AA
//      -> signature=16'h011D, done one cycle later than case 2.
//   6. clear asserted mid-RUN -> next cycle IDLE, all outputs 0; start mid-RUN ignored;
//      start in DONE restarts cleanly and repeats identical signature for same seed.

Source files
------------

// File: rtl/stimulus_signature_unit.sv
// Self-test harness: drives seeded LFSR stimulus into a circuit under test and
// compresses its responses into a 16-bit MISR signature.
module stimulus_signature_unit #(
    parameter int NUM_VECTORS   = 256,
    parameter int CAPTURE_DELAY = 0
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic [7:0]  seed,
    input  logic [7:0]  dut_output,
    output logic [7:0]  dut_input,
    output logic        dut_clear,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature
);

    localparam int RUN_CYCLES = NUM_VECTORS + CAPTURE_DELAY;
    localparam int CW         = $clog2(RUN_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT    = CW'(RUN_CYCLES - 1);
    localparam logic [7:0]    LFSR_TAPS     = 8'h1D;
    localparam logic [15:0]   MISR_TAPS     = 16'h1021;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [7:0]    r_lfsr;
    logic [15:0]   r_misr;
    logic [CW-1:0] r_count;
    logic          r_dut_clear;
    logic          r_busy;
    logic          r_done;

    logic          w_start_ok;
    logic          w_last;
    logic          w_count_ok;
    logic          w_capture;
    logic [7:0]    w_lfsr_step;
    logic [15:0]   w_misr_step;

    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last     = (r_state == S_RUN) && (r_count == LAST_COUNT);

    // The first CAPTURE_DELAY run cycles only fill the DUT pipeline.
    generate
        if (CAPTURE_DELAY == 0) begin : g_no_delay
            assign w_count_ok = 1'b1;
        end else begin : g_delay
            assign w_count_ok = (r_count >= CW'(CAPTURE_DELAY));
        end
    endgenerate

    assign w_capture = (r_state == S_RUN) && w_count_ok;

    assign w_lfsr_step = {r_lfsr[6:0], 1'b0} ^ (r_lfsr[7] ? LFSR_TAPS : 8'h00);
    assign w_misr_step = {r_misr[14:0], 1'b0} ^ (r_misr[15] ? MISR_TAPS : 16'h0000)
                       ^ {8'h00, dut_output};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_INIT;
            S_INIT:  w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  if (start) w_state_next = S_INIT;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state     <= S_IDLE;
            r_lfsr      <= 8'h00;
            r_misr      <= 16'h0000;
            r_count     <= '0;
            r_dut_clear <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            // Status flags are registered from the next state so they never glitch.
            r_dut_clear <= (w_state_next == S_INIT);
            r_busy      <= (w_state_next == S_INIT) || (w_state_next == S_RUN);
            r_done      <= (w_state_next == S_DONE);

            if (w_start_ok) begin
                r_lfsr  <= (seed == 8'h00) ? 8'h01 : seed;
                r_misr  <= 16'h0000;
                r_count <= '0;
            end else if (r_state == S_RUN) begin
                r_count <= r_count + 1'b1;
                // Hold on the final cycle so dut_input keeps the last vector in DONE.
                if (!w_last) begin
                    r_lfsr <= w_lfsr_step;
                end
                if (w_capture) begin
                    r_misr <= w_misr_step;
                end
            end
        end
    end

    assign dut_input = r_lfsr;
    assign dut_clear = r_dut_clear;
    assign busy      = r_busy;
    assign done      = r_done;
    assign signature = r_misr;

endmodule

// File: tb/tb_stimulus_signature_unit.sv
// Directed bench for stimulus_signature_unit: several parameterisations driven
// from a shared stimulus, with hand-computed expected signatures.
module tb_stimulus_signature_unit;

    logic clk;
    logic clear;
    logic start;
    logic start_long;
    logic [7:0] seed;

    // N=1 pass-through
    logic [7:0]  a_in;  logic a_clr, a_busy, a_done;  logic [15:0] a_sig;
    // N=2 pass-through
    logic [7:0]  b_in;  logic b_clr, b_busy, b_done;  logic [15:0] b_sig;
    // N=2, CAPTURE_DELAY=1, registered pass-through
    logic [7:0]  c_in;  logic c_clr, c_busy, c_done;  logic [15:0] c_sig;
    logic [7:0]  c_out_reg;
    // N=256, output tied low
    logic [7:0]  l_in;  logic l_clr, l_busy, l_done;  logic [15:0] l_sig;
    logic [7:0]  zero_out;

    int n_checks = 0;
    int n_fail   = 0;

    stimulus_signature_unit #(.NUM_VECTORS(1), .CAPTURE_DELAY(0)) u_a (
        .clk(clk), .clear(clear), .start(start), .seed(seed), .dut_output(a_in),
        .dut_input(a_in), .dut_clear(a_clr), .busy(a_busy), .done(a_done), .signature(a_sig));

    stimulus_signature_unit #(.NUM_VECTORS(2), .CAPTURE_DELAY(0)) u_b (
        .clk(clk), .clear(clear), .start(start), .seed(seed), .dut_output(b_in),
        .dut_input(b_in), .dut_clear(b_clr), .busy(b_busy), .done(b_done), .signature(b_sig));

    stimulus_signature_unit #(.NUM_VECTORS(2), .CAPTURE_DELAY(1)) u_c (
        .clk(clk), .clear(clear), .start(start), .seed(seed), .dut_output(c_out_reg),
        .dut_input(c_in), .dut_clear(c_clr), .busy(c_busy), .done(c_done), .signature(c_sig));

    stimulus_signature_unit #(.NUM_VECTORS(256), .CAPTURE_DELAY(0)) u_l (
        .clk(clk), .clear(clear), .start(start_long), .seed(seed), .dut_output(zero_out),
        .dut_input(l_in), .dut_clear(l_clr), .busy(l_busy), .done(l_done), .signature(l_sig));

    assign zero_out = 8'h00;

    always @(posedge clk) c_out_reg <= c_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  seed;
        logic [7:0]  in0;   // vector driven in INIT and first RUN cycle
        logic [7:0]  in1;   // second vector
        logic [15:0] sig1;  // NUM_VECTORS=1 signature
        logic [15:0] sig2;  // NUM_VECTORS=2 signature (also delay-1 variant)
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        vecs[0] = '{seed: 8'hAA, in0: 8'hAA, in1: 8'h49, sig1: 16'h00AA, sig2: 16'h011D};
        vecs[1] = '{seed: 8'h00, in0: 8'h01, in1: 8'h02, sig1: 16'h0001, sig2: 16'h0000};
        vecs[2] = '{seed: 8'hFF, in0: 8'hFF, in1: 8'hE3, sig1: 16'h00FF, sig2: 16'h011D};
        vecs[3] = '{seed: 8'h35, in0: 8'h35, in1: 8'h6A, sig1: 16'h0035, sig2: 16'h0000};
        vecs[4] = '{seed: 8'h80, in0: 8'h80, in1: 8'h1D, sig1: 16'h0080, sig2: 16'h011D};

        clear = 1'b1; start = 1'b0; start_long = 1'b0; seed = 8'h00;
        tick();
        tick();
        chk("reset_busy", {31'd0, b_busy}, 32'd0);
        chk("reset_done", {31'd0, b_done}, 32'd0);
        chk("reset_dut_clear", {31'd0, b_clr}, 32'd0);
        chk("reset_dut_input", {24'd0, b_in}, 32'd0);
        chk("reset_signature", {16'd0, b_sig}, 32'd0);
        clear = 1'b0;
        tick();
        chk("idle_done", {31'd0, a_done}, 32'd0);

        // Table: first entry starts from IDLE, the rest restart from DONE.
        for (int i = 0; i < 5; i++) begin
            seed = vecs[i].seed;
            start = 1'b1;
            tick();
            start = 1'b0;
            chk($sformatf("v%0d_init_clear", i), {31'd0, a_clr}, 32'd1);
            chk($sformatf("v%0d_init_busy", i), {31'd0, a_busy}, 32'd1);
            chk($sformatf("v%0d_init_done", i), {31'd0, a_done}, 32'd0);
            chk($sformatf("v%0d_init_input", i), {24'd0, a_in}, {24'd0, vecs[i].in0});
            tick();
            chk($sformatf("v%0d_run_clear", i), {31'd0, a_clr}, 32'd0);
            chk($sformatf("v%0d_run0_input", i), {24'd0, b_in}, {24'd0, vecs[i].in0});
            tick();
            chk($sformatf("v%0d_n1_done", i), {31'd0, a_done}, 32'd1);
            chk($sformatf("v%0d_n1_busy", i), {31'd0, a_busy}, 32'd0);
            chk($sformatf("v%0d_n1_sig", i), {16'd0, a_sig}, {16'd0, vecs[i].sig1});
            chk($sformatf("v%0d_run1_input", i), {24'd0, b_in}, {24'd0, vecs[i].in1});
            chk($sformatf("v%0d_n2_not_done", i), {31'd0, b_done}, 32'd0);
            tick();
            chk($sformatf("v%0d_n2_done", i), {31'd0, b_done}, 32'd1);
            chk($sformatf("v%0d_n2_sig", i), {16'd0, b_sig}, {16'd0, vecs[i].sig2});
            chk($sformatf("v%0d_n2_hold_input", i), {24'd0, b_in}, {24'd0, vecs[i].in1});
            chk($sformatf("v%0d_d1_not_done", i), {31'd0, c_done}, 32'd0);
            tick();
            chk($sformatf("v%0d_d1_done", i), {31'd0, c_done}, 32'd1);
            chk($sformatf("v%0d_d1_sig", i), {16'd0, c_sig}, {16'd0, vecs[i].sig2});
            chk($sformatf("v%0d_n1_sig_frozen", i), {16'd0, a_sig}, {16'd0, vecs[i].sig1});
            tick();
        end

        // Start asserted mid-RUN must not disturb the run in progress.
        seed = 8'hAA;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        seed = 8'h35;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("midstart_n1_sig", {16'd0, a_sig}, 32'h00AA);
        chk("midstart_n2_input", {24'd0, b_in}, 32'h49);
        chk("midstart_n2_busy", {31'd0, b_busy}, 32'd1);
        tick();
        chk("midstart_n2_done", {31'd0, b_done}, 32'd1);
        chk("midstart_n2_sig", {16'd0, b_sig}, 32'h011D);
        tick();

        // Long run aborted by clear mid-RUN.
        seed = 8'h5A;
        start_long = 1'b1;
        tick();
        start_long = 1'b0;
        chk("long_init_input", {24'd0, l_in}, 32'h5A);
        for (int k = 0; k < 10; k++) tick();
        chk("long_mid_busy", {31'd0, l_busy}, 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("abort_busy", {31'd0, l_busy}, 32'd0);
        chk("abort_done", {31'd0, l_done}, 32'd0);
        chk("abort_input", {24'd0, l_in}, 32'd0);
        chk("abort_clear_out", {31'd0, l_clr}, 32'd0);
        chk("abort_sig", {16'd0, l_sig}, 32'd0);
        tick();
        chk("abort_stays_idle", {31'd0, l_busy}, 32'd0);

        // Full 256-vector run with a zero response.
        seed = 8'hC3;
        start_long = 1'b1;
        tick();
        start_long = 1'b0;
        cyc = 0;
        while (!l_done && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("long_done_cycle", cyc, 32'd257);
        chk("long_sig", {16'd0, l_sig}, 32'd0);
        tick();
        tick();
        chk("long_done_held", {31'd0, l_done}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
